// File: rtl/xor5_arbiter_if.sv
// ---------------------------------------------------------------------------
// xor5_arbiter_if
// Bus bundle between the requesters and the shared 5-input XOR arbiter.
//   req       : per-requester request level (requester -> arbiter)
//   data      : packed operands, requester i at [i*W +: W] (requester -> arbiter)
//   gnt       : registered one-hot grant (arbiter -> requester)
//   ack       : one-cycle completion pulse (arbiter -> requester)
//   po        : parity result, XOR of the 5 operand bits
//   po_valid  : qualifies po / po_id
//   po_id     : index of the requester owning po
//   abort_cnt : saturating count of aborted transactions
// ---------------------------------------------------------------------------
interface xor5_arbiter_if #(
   parameter int N_REQ = 4,
   parameter int W     = 5,
   parameter int IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
   logic [N_REQ-1:0]   req;
   logic [N_REQ*W-1:0] data;
   logic [N_REQ-1:0]   gnt;
   logic [N_REQ-1:0]   ack;
   logic               po;
   logic               po_valid;
   logic [IDW-1:0]     po_id;
   logic [7:0]         abort_cnt;

   // Requester side: drives requests and operands, observes results.
   modport master (
      output req,
      output data,
      input  gnt,
      input  ack,
      input  po,
      input  po_valid,
      input  po_id,
      input  abort_cnt
   );

   // Arbiter side: consumes requests and operands, produces results.
   modport slave (
      input  req,
      input  data,
      output gnt,
      output ack,
      output po,
      output po_valid,
      output po_id,
      output abort_cnt
   );
endinterface

// File: rtl/xor5_arbiter.sv
// ---------------------------------------------------------------------------
// xor5_arbiter
// Round-robin arbiter sharing one 5-input XOR (parity) unit between N_REQ
// requesters. A transaction is IDLE (pick + capture operand) -> EVAL
// (compute parity, or abort if the request was withdrawn) -> DONE (pulse
// ack/po_valid). All outputs are registered.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : xor5_arbiter_if.slave (req, data in; gnt, ack, po, po_valid,
//         po_id, abort_cnt out)
// ---------------------------------------------------------------------------
module xor5_arbiter #(
   parameter int N_REQ = 4,
   parameter int W     = 5
) (
   input  logic           clk,
   input  logic           rst,
   xor5_arbiter_if.slave  bus
);

   localparam int IDW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EVAL = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   // -------------------------------------------------------------------
   // Helpers
   // -------------------------------------------------------------------

   // Parity of one operand: 1 when an odd number of bits are set.
   function automatic logic parity_w(input logic [W-1:0] v);
      logic p;
      p = 1'b0;
      for (int b = 0; b < W; b++) begin
         p = p ^ v[b];
      end
      return p;
   endfunction

   // One-hot vector with bit i set.
   function automatic logic [N_REQ-1:0] onehot(input logic [IDW-1:0] i);
      logic [N_REQ-1:0] v;
      v    = {N_REQ{1'b0}};
      v[i] = 1'b1;
      return v;
   endfunction

   // Round-robin pick: first requesting index strictly after p, wrapping,
   // with p itself as the lowest priority. The loop walks from the farthest
   // candidate to the nearest so the nearest requester overwrites the pick.
   function automatic logic [IDW-1:0] rr_pick(input logic [N_REQ-1:0] r,
                                              input logic [IDW-1:0]   p);
      logic [IDW-1:0] pick;
      logic [IDW:0]   sum;
      logic [IDW-1:0] idx;
      pick = p;
      for (int off = N_REQ; off >= 1; off--) begin
         sum = {1'b0, p} + (IDW+1)'(off);
         if (sum >= (IDW+1)'(N_REQ)) begin
            sum = sum - (IDW+1)'(N_REQ);
         end else begin
            sum = sum;
         end
         idx = sum[IDW-1:0];
         if (r[idx]) begin
            pick = idx;
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // -------------------------------------------------------------------
   // State
   // -------------------------------------------------------------------
   state_t           state_q,     state_d;
   logic [N_REQ-1:0] gnt_q,       gnt_d;
   logic [N_REQ-1:0] ack_q,       ack_d;
   logic             po_q,        po_d;
   logic             po_valid_q,  po_valid_d;
   logic [IDW-1:0]   po_id_q,     po_id_d;
   logic [7:0]       abort_cnt_q, abort_cnt_d;
   logic [W-1:0]     op_q,        op_d;
   logic [IDW-1:0]   id_q,        id_d;
   logic [IDW-1:0]   ptr_q,       ptr_d;
   // Parity is computed in EVAL but only published in DONE, so po keeps
   // its previous value while po_valid is low.
   logic             par_q,       par_d;

   logic [IDW-1:0]   sel_s;
   logic             any_req_s;

   // Round-robin selection relative to the last served/aborted index.
   always_comb begin
      any_req_s = (bus.req != {N_REQ{1'b0}});
      sel_s     = rr_pick(bus.req, ptr_q);
   end

   // Next-state and output logic of the transaction FSM.
   always_comb begin
      state_d     = state_q;
      gnt_d       = gnt_q;
      ack_d       = {N_REQ{1'b0}};
      po_d        = po_q;
      po_valid_d  = 1'b0;
      po_id_d     = po_id_q;
      abort_cnt_d = abort_cnt_q;
      op_d        = op_q;
      id_d        = id_q;
      ptr_d       = ptr_q;
      par_d       = par_q;

      case (state_q)
         ST_IDLE: begin
            if (any_req_s) begin
               // Operand is captured exactly once, here.
               op_d    = bus.data[int'(sel_s)*W +: W];
               gnt_d   = onehot(sel_s);
               id_d    = sel_s;
               state_d = ST_EVAL;
            end else begin
               gnt_d   = {N_REQ{1'b0}};
               state_d = ST_IDLE;
            end
         end

         ST_EVAL: begin
            if (bus.req[id_q]) begin
               par_d   = parity_w(op_q);
               state_d = ST_DONE;
            end else begin
               // Requester withdrew: drop the transaction silently.
               gnt_d   = {N_REQ{1'b0}};
               ptr_d   = id_q;
               state_d = ST_IDLE;
               if (abort_cnt_q != 8'hFF) begin
                  abort_cnt_d = abort_cnt_q + 8'd1;
               end else begin
                  abort_cnt_d = abort_cnt_q;
               end
            end
         end

         ST_DONE: begin
            ack_d      = onehot(id_q);
            po_valid_d = 1'b1;
            po_d       = par_q;
            po_id_d    = id_q;
            gnt_d      = {N_REQ{1'b0}};
            ptr_d      = id_q;
            state_d    = ST_IDLE;
         end

         default: begin
            gnt_d   = {N_REQ{1'b0}};
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers; ptr resets to the last index so that
   // requester 0 has first priority after reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         gnt_q       <= {N_REQ{1'b0}};
         ack_q       <= {N_REQ{1'b0}};
         po_q        <= 1'b0;
         po_valid_q  <= 1'b0;
         po_id_q     <= {IDW{1'b0}};
         abort_cnt_q <= 8'd0;
         op_q        <= {W{1'b0}};
         id_q        <= {IDW{1'b0}};
         ptr_q       <= IDW'(N_REQ - 1);
         par_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         gnt_q       <= gnt_d;
         ack_q       <= ack_d;
         po_q        <= po_d;
         po_valid_q  <= po_valid_d;
         po_id_q     <= po_id_d;
         abort_cnt_q <= abort_cnt_d;
         op_q        <= op_d;
         id_q        <= id_d;
         ptr_q       <= ptr_d;
         par_q       <= par_d;
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.ack       = ack_q;
   assign bus.po        = po_q;
   assign bus.po_valid  = po_valid_q;
   assign bus.po_id     = po_id_q;
   assign bus.abort_cnt = abort_cnt_q;

endmodule

// File: tb/tb_xor5_arbiter.sv
// ---------------------------------------------------------------------------
// tb_xor5_arbiter
// Directed bench for xor5_arbiter with N_REQ=4, W=5.
// ---------------------------------------------------------------------------
module tb_xor5_arbiter;

   logic clk;
   logic rst;
   int   tests;
   int   fails;

   xor5_arbiter_if #(.N_REQ(4), .W(5)) bus_if ();

   xor5_arbiter #(.N_REQ(4), .W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // 10-unit clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Compare and count.
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reference parity by counting ones.
   function automatic logic ref_par(input logic [4:0] v);
      int n;
      n = 0;
      for (int b = 0; b < 5; b++) n += int'(v[b]);
      return logic'(n % 2);
   endfunction

   int seen;
   int cyc;
   int last_cyc;
   logic [3:0] fair_par;

   initial begin
      tests = 0;
      fails = 0;
      rst = 1'b1;
      bus_if.req  = 4'b0000;
      bus_if.data = 20'd0;

      // ---- reset state
      step();
      step();
      chk("rst_gnt",      32'(bus_if.gnt),       32'h0);
      chk("rst_ack",      32'(bus_if.ack),       32'h0);
      chk("rst_po",       32'(bus_if.po),        32'h0);
      chk("rst_po_valid", 32'(bus_if.po_valid),  32'h0);
      chk("rst_po_id",    32'(bus_if.po_id),     32'h0);
      chk("rst_abort",    32'(bus_if.abort_cnt), 32'h0);
      rst = 1'b0;

      // ---- idle with no request
      step();
      chk("idle_gnt", 32'(bus_if.gnt), 32'h0);
      chk("idle_pov", 32'(bus_if.po_valid), 32'h0);

      // ---- single request: req0, operand 10110 (parity 1)
      bus_if.req       = 4'b0001;
      bus_if.data[4:0] = 5'b10110;
      step();
      chk("single_gnt_k",  32'(bus_if.gnt), 32'h1);
      chk("single_ack_k",  32'(bus_if.ack), 32'h0);
      step();
      chk("single_gnt_k1", 32'(bus_if.gnt), 32'h1);
      chk("single_pov_k1", 32'(bus_if.po_valid), 32'h0);
      chk("single_po_k1",  32'(bus_if.po), 32'h0);
      step();
      chk("single_ack",    32'(bus_if.ack), 32'h1);
      chk("single_pov",    32'(bus_if.po_valid), 32'h1);
      chk("single_po",     32'(bus_if.po), 32'h1);
      chk("single_po_id",  32'(bus_if.po_id), 32'h0);
      chk("single_gnt_cl", 32'(bus_if.gnt), 32'h0);
      bus_if.req = 4'b0000;
      step();
      chk("hold_ack", 32'(bus_if.ack), 32'h0);
      chk("hold_pov", 32'(bus_if.po_valid), 32'h0);
      chk("hold_po",  32'(bus_if.po), 32'h1);
      chk("hold_gnt", 32'(bus_if.gnt), 32'h0);

      // ---- exhaustive parity on requester 2
      for (int v = 0; v < 32; v++) begin
         logic [4:0] vv;
         vv = 5'(v);
         bus_if.data[14:10] = vv;
         bus_if.req = 4'b0100;
         step();
         chk("ex_gnt", 32'(bus_if.gnt), 32'h4);
         step();
         step();
         chk("ex_pov", 32'(bus_if.po_valid), 32'h1);
         chk("ex_po",  32'(bus_if.po), 32'(ref_par(vv)));
         chk("ex_id",  32'(bus_if.po_id), 32'h2);
         if (v == 0)  chk("ex_po_00000", 32'(bus_if.po), 32'h0);
         if (v == 31) chk("ex_po_11111", 32'(bus_if.po), 32'h1);
         if (v == 24) chk("ex_po_11000", 32'(bus_if.po), 32'h0);
         bus_if.req = 4'b0000;
         step();
      end

      // ---- fairness from a fresh reset: all four requesting
      rst = 1'b1;
      step();
      rst = 1'b0;
      // req0 01111 ->0, req1 00111 ->1, req2 00011 ->0, req3 00001 ->1
      bus_if.data = {5'b00001, 5'b00011, 5'b00111, 5'b01111};
      fair_par = 4'b1010;
      bus_if.req = 4'b1111;
      seen = 0;
      cyc = 0;
      last_cyc = -1;
      while (seen < 12 && cyc < 80) begin
         step();
         cyc++;
         chk("fair_gnt_onehot", 32'($countones(bus_if.gnt) <= 1), 32'h1);
         if (bus_if.po_valid === 1'b1) begin
            chk("fair_id",  32'(bus_if.po_id), 32'(seen % 4));
            chk("fair_po",  32'(bus_if.po), 32'(fair_par[seen % 4]));
            chk("fair_ack", 32'(bus_if.ack), 32'(4'b0001 << (seen % 4)));
            if (last_cyc >= 0) chk("fair_gap", 32'(cyc - last_cyc), 32'd3);
            last_cyc = cyc;
            seen++;
            if (seen == 12) bus_if.req = 4'b0000;
         end
      end
      chk("fair_count", 32'(seen), 32'd12);
      step();

      // ---- abort: requester 1 granted, then withdraws (ptr is 3 here)
      bus_if.req = 4'b0010;
      step();
      chk("ab_gnt1", 32'(bus_if.gnt), 32'h2);
      bus_if.req = 4'b0100;
      step();
      chk("ab_gnt_cl", 32'(bus_if.gnt), 32'h0);
      chk("ab_ack",    32'(bus_if.ack), 32'h0);
      chk("ab_pov",    32'(bus_if.po_valid), 32'h0);
      chk("ab_cnt1",   32'(bus_if.abort_cnt), 32'd1);
      step();
      chk("ab_next_gnt", 32'(bus_if.gnt), 32'h4);
      step();
      step();
      chk("ab_next_ack", 32'(bus_if.ack), 32'h4);
      chk("ab_next_id",  32'(bus_if.po_id), 32'h2);
      chk("ab_next_po",  32'(bus_if.po), 32'h0);
      bus_if.req = 4'b0000;
      step();

      // ---- abort counter saturation
      for (int i = 2; i <= 300; i++) begin
         bus_if.req = 4'b0001;
         step();
         bus_if.req = 4'b0000;
         step();
         if (i == 254) chk("ab_cnt254", 32'(bus_if.abort_cnt), 32'd254);
         if (i == 255) chk("ab_cnt255", 32'(bus_if.abort_cnt), 32'd255);
      end
      chk("ab_cnt_sat", 32'(bus_if.abort_cnt), 32'd255);
      chk("ab_sat_ack", 32'(bus_if.ack), 32'h0);

      // ---- operand change during EVAL is ignored
      bus_if.data[4:0] = 5'b10110;
      bus_if.req = 4'b0001;
      step();
      chk("opc_gnt", 32'(bus_if.gnt), 32'h1);
      bus_if.data[4:0] = 5'b10111;
      step();
      bus_if.data[4:0] = 5'b00000;
      step();
      chk("opc_ack", 32'(bus_if.ack), 32'h1);
      chk("opc_po",  32'(bus_if.po), 32'h1);
      bus_if.req = 4'b0000;
      step();

      // ---- reset while in DONE
      bus_if.req = 4'b0001;
      step();
      step();
      chk("rd_gnt_pre", 32'(bus_if.gnt), 32'h1);
      rst = 1'b1;
      #1;
      chk("rd_gnt", 32'(bus_if.gnt), 32'h0);
      chk("rd_ack", 32'(bus_if.ack), 32'h0);
      chk("rd_pov", 32'(bus_if.po_valid), 32'h0);
      chk("rd_cnt", 32'(bus_if.abort_cnt), 32'h0);
      step();
      chk("rd_ack_hold", 32'(bus_if.ack), 32'h0);
      bus_if.req = 4'b1010;
      rst = 1'b0;
      step();
      chk("rd_first_gnt", 32'(bus_if.gnt), 32'h2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
